fprint_vote_comparator: RTL and testbench
=========================================

Name: fprint_vote_comparator

Overview:
Parametrised successor of the fixed 3-core/16-task fingerprint comparator. It selects a pending task by round-robin arbitration, majority-votes fingerprints from NUM_CORES redundant cores, and identifies which cores disagree. It drives the fprint, oflow and comp register-bank handshakes and writes the result to the CSR block. It sits between the fingerprint register banks and the CSR status register in the fprint unit.

Parameters:
NUM_TASKS, 16, task slots; power of two, 2..64
KEY_W, 4, log2(NUM_TASKS)
CRC_W, 32, fingerprint width
NUM_CORES, 3, redundant cores, 2..4
CORE_ID_W, 2, logical core id width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
mode_nmr  in  1  1 = vote across active cores; 0 = DMR on cores 0,1 only
core_active  in  NUM_CORES  per-core enable for the vote
fprints  in  NUM_CORES*CRC_W  packed fingerprints; core i at [i*CRC_W +: CRC_W]
task_ready  in  NUM_TASKS  oflow fingerprints ready per task
task_checkin  in  NUM_TASKS  task checked in
task_remaining  in  NUM_TASKS  fingerprints still outstanding
remaining_core_id  in  CORE_ID_W  core owning the outstanding fingerprints
task_id  out  KEY_W  latched task under comparison
inc_tail_req / inc_tail_ack  out/in  1  advance comp tail pointer
count_dec_req / count_dec_ack  out/in  1  decrement oflow count
fprint_rst_req / fprint_rst_ack  out/in  1  clear fprint task
comp_rst_req / comp_rst_ack  out/in  1  clear comp task
oflow_rst_req / oflow_rst_ack  out/in  1  clear oflow task
status_wr / status_ack  out/in  1  CSR status write
mismatch  out  1  mismatch flag for the current task
faulty_mask  out  NUM_CORES  disagreeing cores
faulty_core_id  out  CORE_ID_W  lowest faulty core; all-ones means undetermined
timeout_err  out  1  ack timeout (optional feature only)

Behaviour:
- Reset values: state IDLE; task_id = 0; rr_ptr = 0; mismatch = 0; faulty_mask = 0; faulty_core_id = all-ones; every req = 0; timeout_err = 0.
- Arbitration: pending = task_ready | task_checkin. Pick the first set bit at or after rr_ptr, wrapping modulo NUM_TASKS. In SET_TASK, task_id is latched and rr_ptr becomes task_id+1 (wraps to 0).
- States: IDLE -> SET_TASK (when any pending bit is set) -> LOAD_PTR -> LOAD_FPRINT -> CHECK.
- CHECK:
  - task_ready[task_id] -> COMPARE.
  - else task_checkin[task_id]: task_remaining -> MISMATCH, otherwise -> FPRINT_RST.
  - else -> IDLE.
- COMPARE: agree -> INC_TAIL, otherwise -> MISMATCH.
- Request/ack chain: INC_TAIL (inc_tail_ack) -> COUNT_DEC (count_dec_ack) -> CHECK. MISMATCH (1 cycle) -> FPRINT_RST (fprint_rst_ack) -> COMP_RST (comp_rst_ack).
- After COMP_RST: OFLOW_RST if mismatch, otherwise STATUS_WR. OFLOW_RST (oflow_rst_ack) -> STATUS_WR (status_ack) -> IDLE.
- Each req is a Moore output, asserted exactly while in its state. The state is held until the ack is seen high on a clock edge; an ack outside its state is ignored.
- Vote (combinational):
  - Active set = core_active, restricted to cores {0,1} when mode_nmr = 0.
  - Core i's support = number of active cores j with fprints equal to core i's (j = i counts).
  - Majority exists if some core's support > active_count/2. Agree = support equals active_count.
  - faulty_mask = active cores not equal to the majority value. If there is no majority, faulty_mask = all active cores.
- Entering MISMATCH:
  - From the task_remaining path: faulty_mask = 1<<remaining_core_id; faulty_core_id = remaining_core_id.
  - From COMPARE: faulty_mask and faulty_core_id come from the vote. faulty_core_id = all-ones if there is no majority.
  - mismatch is set; it is cleared in IDLE.
- Boundaries:
  - active_count < 2: treated as agree.
  - DMR mismatch: no majority -> faulty_core_id all-ones.
  - Pending bits may change after SET_TASK without effect, since task_id is locked.
  - Reset mid-handshake returns to IDLE and drops all reqs asynchronously.

Optional Feature:
FVC_ACK_TIMEOUT_EN, with localparam TIMEOUT = 1023.
- Defined: a 10-bit counter clears on every state change and increments while in a req state. On reaching TIMEOUT: timeout_err is set (sticky until reset), mismatch = 1, faulty_core_id = all-ones, and the FSM jumps to STATUS_WR. A timeout in STATUS_WR itself goes to IDLE.
- Undefined: no counter exists and timeout_err is tied to 0.

Decomposition:
- Shared package fvc_pkg holds the state encoding localparams and ALL_ONES_CORE_ID.
- One sub-module, fvc_vote: purely combinational fingerprint voter. Inputs: fprints, active set. Outputs: agree, majority_found, faulty_mask.
- The FSM and the round-robin arbiter stay in the top-level module.

Test Plan:
- NMR match: task 5 ready, fprints all 0xDEADBEEF -> inc_tail then count_dec handshakes; task 5 de-asserts ready and checkin set -> FPRINT_RST, COMP_RST, STATUS_WR; mismatch = 0.
- Single fault: core 2 = 0x1 with cores 0,1 = 0xA -> faulty_mask = 3'b100, faulty_core_id = 2, oflow_rst_req issued.
- DMR mismatch: mode_nmr = 0, core 0 = 0xA, core 1 = 0xB -> faulty_mask = 2'b11 (core 2 excluded), faulty_core_id = 3.
- Round-robin: tasks 0 and 3 pending continuously -> served order 0, 3, 0; not 0, 0.
- Remaining path: checkin[7] with task_remaining[7], remaining_core_id = 1 -> mismatch = 1, faulty_core_id = 1.
- Timeout (macro defined): withhold comp_rst_ack -> after 1023 cycles timeout_err = 1 and status_wr asserted.

Source files
------------

// File: rtl/fvc_pkg.sv
// Shared definitions for the fingerprint vote comparator: FSM state encoding and core-id sentinel.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package fvc_pkg;

  localparam int FVC_STATE_W = 4;

  typedef enum logic [FVC_STATE_W-1:0] {
    ST_IDLE        = 4'd0,
    ST_SET_TASK    = 4'd1,
    ST_LOAD_PTR    = 4'd2,
    ST_LOAD_FPRINT = 4'd3,
    ST_CHECK       = 4'd4,
    ST_COMPARE     = 4'd5,
    ST_INC_TAIL    = 4'd6,
    ST_COUNT_DEC   = 4'd7,
    ST_MISMATCH    = 4'd8,
    ST_FPRINT_RST  = 4'd9,
    ST_COMP_RST    = 4'd10,
    ST_OFLOW_RST   = 4'd11,
    ST_STATUS_WR   = 4'd12
  } state_e;

  // Wide enough for any supported CORE_ID_W; users slice the low bits.
  localparam logic [7:0] ALL_ONES_CORE_ID = 8'hFF;

endpackage

// File: rtl/fvc_vote.sv
// Combinational majority voter over NUM_CORES fingerprints, reporting agreement and dissenters.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow inputs.
module fvc_vote #(
  parameter int NUM_CORES = 3,
  parameter int CRC_W     = 32
) (
  input  logic [NUM_CORES*CRC_W-1:0] fprints,
  input  logic [NUM_CORES-1:0]       active,
  output logic                       agree,
  output logic                       majority_found,
  output logic [NUM_CORES-1:0]       faulty_mask
);

  localparam int CNT_W = $clog2(NUM_CORES + 1);

  logic [CRC_W-1:0] fp [NUM_CORES];
  logic [CNT_W-1:0] support [NUM_CORES];
  logic [CNT_W-1:0] active_cnt;
  logic [CRC_W-1:0] maj_val;

  // Unpack the per-core fingerprints and count the active cores.
  always_comb begin
    active_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      fp[i]      = fprints[i*CRC_W +: CRC_W];
      active_cnt = active_cnt + CNT_W'(active[i]);
    end
  end

  // Support of core i: active cores (itself included) holding the same fingerprint.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      support[i] = '0;
      for (int j = 0; j < NUM_CORES; j++) begin
        if (active[j] && (fp[j] == fp[i])) support[i] = support[i] + CNT_W'(1);
      end
    end
  end

  // Majority needs strictly more than half; fewer than two voters always agree.
  always_comb begin
    majority_found = 1'b0;
    maj_val        = '0;
    agree          = (active_cnt < CNT_W'(2));
    for (int i = 0; i < NUM_CORES; i++) begin
      if (active[i] && ({support[i], 1'b0} > {1'b0, active_cnt})) begin
        majority_found = 1'b1;
        maj_val        = fp[i];
      end
      if (active[i] && (support[i] == active_cnt)) agree = 1'b1;
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      faulty_mask[i] = active[i] && (!majority_found || (fp[i] != maj_val));
    end
  end

endmodule

// File: rtl/fprint_vote_comparator.sv
// Round-robin task picker + redundant-core fingerprint vote; drives reg-bank clears and CSR status write. Optional FVC_ACK_TIMEOUT_EN adds an ack watchdog.
// Latency: 4 cycles from pending to COMPARE/CHECK decision, then one state per handshake.
// Backpressure: every req is held (Moore) until its ack is sampled high; foreign acks are ignored.
module fprint_vote_comparator
  import fvc_pkg::*;
#(
  parameter int NUM_TASKS = 16,
  parameter int KEY_W     = 4,
  parameter int CRC_W     = 32,
  parameter int NUM_CORES = 3,
  parameter int CORE_ID_W = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mode_nmr,
  input  logic [NUM_CORES-1:0]       core_active,
  input  logic [NUM_CORES*CRC_W-1:0] fprints,
  input  logic [NUM_TASKS-1:0]       task_ready,
  input  logic [NUM_TASKS-1:0]       task_checkin,
  input  logic [NUM_TASKS-1:0]       task_remaining,
  input  logic [CORE_ID_W-1:0]       remaining_core_id,
  output logic [KEY_W-1:0]           task_id,
  output logic                       inc_tail_req,
  input  logic                       inc_tail_ack,
  output logic                       count_dec_req,
  input  logic                       count_dec_ack,
  output logic                       fprint_rst_req,
  input  logic                       fprint_rst_ack,
  output logic                       comp_rst_req,
  input  logic                       comp_rst_ack,
  output logic                       oflow_rst_req,
  input  logic                       oflow_rst_ack,
  output logic                       status_wr,
  input  logic                       status_ack,
  output logic                       mismatch,
  output logic [NUM_CORES-1:0]       faulty_mask,
  output logic [CORE_ID_W-1:0]       faulty_core_id,
  output logic                       timeout_err
);

  localparam logic [CORE_ID_W-1:0] NO_CORE  = ALL_ONES_CORE_ID[CORE_ID_W-1:0];
  localparam logic [NUM_CORES-1:0] DMR_MASK = NUM_CORES'(3);

  state_e                 state_q, state_d;
  logic [KEY_W-1:0]       task_id_q, task_id_d, rr_ptr_q, rr_ptr_d, pick;
  logic                   mismatch_q, mismatch_d;
  logic [NUM_CORES-1:0]   faulty_mask_q, faulty_mask_d, rem_mask, vote_mask, vote_active;
  logic [CORE_ID_W-1:0]   faulty_id_q, faulty_id_d, vote_id;
  logic [NUM_TASKS-1:0]   pending;
  logic                   vote_agree, vote_majority, tmo_hit;

  assign pending     = task_ready | task_checkin;
  assign vote_active = core_active & (mode_nmr ? {NUM_CORES{1'b1}} : DMR_MASK);

  fvc_vote #(.NUM_CORES(NUM_CORES), .CRC_W(CRC_W)) u_vote (
    .fprints        (fprints),
    .active         (vote_active),
    .agree          (vote_agree),
    .majority_found (vote_majority),
    .faulty_mask    (vote_mask)
  );

  // First pending task at or after rr_ptr, wrapping; descending scan lets the nearest win.
  always_comb begin
    pick = rr_ptr_q;
    for (int k = NUM_TASKS - 1; k >= 0; k--) begin
      if (pending[rr_ptr_q + KEY_W'(k)]) pick = rr_ptr_q + KEY_W'(k);
    end
  end

  // Lowest dissenting core, or the sentinel when the vote had no majority.
  always_comb begin
    vote_id = NO_CORE;
    if (vote_majority) begin
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
        if (vote_mask[i]) vote_id = CORE_ID_W'(i);
      end
    end
  end

  // One-hot of the core still owing fingerprints; out-of-range ids give an empty mask.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) rem_mask[i] = (remaining_core_id == CORE_ID_W'(i));
  end

  // Next-state and result capture; watchdog overrides the normal transition.
  always_comb begin
    state_d       = state_q;
    task_id_d     = task_id_q;
    rr_ptr_d      = rr_ptr_q;
    mismatch_d    = mismatch_q;
    faulty_mask_d = faulty_mask_q;
    faulty_id_d   = faulty_id_q;
    case (state_q)
      ST_IDLE: begin
        mismatch_d = 1'b0;
        if (|pending) state_d = ST_SET_TASK;
      end
      ST_SET_TASK: begin
        task_id_d = pick;
        rr_ptr_d  = pick + KEY_W'(1);
        state_d   = ST_LOAD_PTR;
      end
      ST_LOAD_PTR:    state_d = ST_LOAD_FPRINT;
      ST_LOAD_FPRINT: state_d = ST_CHECK;
      ST_CHECK: begin
        if (task_ready[task_id_q]) begin
          state_d = ST_COMPARE;
        end else if (task_checkin[task_id_q]) begin
          if (task_remaining[task_id_q]) begin
            state_d       = ST_MISMATCH;
            mismatch_d    = 1'b1;
            faulty_mask_d = rem_mask;
            faulty_id_d   = remaining_core_id;
          end else begin
            state_d = ST_FPRINT_RST;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COMPARE: begin
        if (vote_agree) begin
          state_d = ST_INC_TAIL;
        end else begin
          state_d       = ST_MISMATCH;
          mismatch_d    = 1'b1;
          faulty_mask_d = vote_mask;
          faulty_id_d   = vote_id;
        end
      end
      ST_INC_TAIL:   if (inc_tail_ack)   state_d = ST_COUNT_DEC;
      ST_COUNT_DEC:  if (count_dec_ack)  state_d = ST_CHECK;
      ST_MISMATCH:   state_d = ST_FPRINT_RST;
      ST_FPRINT_RST: if (fprint_rst_ack) state_d = ST_COMP_RST;
      ST_COMP_RST:   if (comp_rst_ack)   state_d = mismatch_q ? ST_OFLOW_RST : ST_STATUS_WR;
      ST_OFLOW_RST:  if (oflow_rst_ack)  state_d = ST_STATUS_WR;
      ST_STATUS_WR:  if (status_ack)     state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
    if (tmo_hit) begin
      state_d     = (state_q == ST_STATUS_WR) ? ST_IDLE : ST_STATUS_WR;
      mismatch_d  = 1'b1;
      faulty_id_d = NO_CORE;
    end
  end

  // State and captured-result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      task_id_q     <= '0;
      rr_ptr_q      <= '0;
      mismatch_q    <= 1'b0;
      faulty_mask_q <= '0;
      faulty_id_q   <= NO_CORE;
    end else begin
      state_q       <= state_d;
      task_id_q     <= task_id_d;
      rr_ptr_q      <= rr_ptr_d;
      mismatch_q    <= mismatch_d;
      faulty_mask_q <= faulty_mask_d;
      faulty_id_q   <= faulty_id_d;
    end
  end

  assign inc_tail_req   = (state_q == ST_INC_TAIL);
  assign count_dec_req  = (state_q == ST_COUNT_DEC);
  assign fprint_rst_req = (state_q == ST_FPRINT_RST);
  assign comp_rst_req   = (state_q == ST_COMP_RST);
  assign oflow_rst_req  = (state_q == ST_OFLOW_RST);
  assign status_wr      = (state_q == ST_STATUS_WR);
  assign task_id        = task_id_q;
  assign mismatch       = mismatch_q;
  assign faulty_mask    = faulty_mask_q;
  assign faulty_core_id = faulty_id_q;

`ifdef FVC_ACK_TIMEOUT_EN
  localparam logic [9:0] TIMEOUT = 10'd1023;

  logic [9:0] tmo_cnt_q, tmo_cnt_d;
  logic       tmo_err_q, in_req;

  assign in_req  = inc_tail_req | count_dec_req | fprint_rst_req |
                   comp_rst_req | oflow_rst_req | status_wr;
  assign tmo_hit = in_req && (tmo_cnt_q == TIMEOUT);

  // Count cycles spent waiting in one req state; any state change restarts it.
  always_comb begin
    tmo_cnt_d = '0;
    if ((state_d == state_q) && in_req) tmo_cnt_d = tmo_cnt_q + 10'd1;
  end

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_q | tmo_hit;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_fprint_vote_comparator.sv
// Self-checking bench: directed scenarios plus randomized tasks against a behavioural vote/arbiter model.
// Latency: n/a.
// Backpressure: bench acks each req one cycle after seeing it.
module tb_fprint_vote_comparator;

  localparam int NT = 16;
  localparam int KW = 4;
  localparam int CW = 32;
  localparam int NC = 3;
  localparam int IW = 2;
  localparam int R_INC = 0, R_CNT = 1, R_FPR = 2, R_CMP = 3, R_OFL = 4, R_STS = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              mode_nmr;
  logic [NC-1:0]     core_active;
  logic [CW-1:0]     fp [NC];
  logic [NC*CW-1:0]  fprints;
  logic [NT-1:0]     task_ready, task_checkin, task_remaining;
  logic [IW-1:0]     remaining_core_id;
  logic [5:0]        acks;
  logic [KW-1:0]     task_id;
  logic              inc_tail_req, count_dec_req, fprint_rst_req, comp_rst_req, oflow_rst_req, status_wr;
  logic              mismatch, timeout_err;
  logic [NC-1:0]     faulty_mask;
  logic [IW-1:0]     faulty_core_id;
  logic [5:0]        reqs;

  assign fprints = {fp[2], fp[1], fp[0]};
  assign reqs    = {status_wr, oflow_rst_req, comp_rst_req, fprint_rst_req, count_dec_req, inc_tail_req};

  fprint_vote_comparator #(
    .NUM_TASKS(NT), .KEY_W(KW), .CRC_W(CW), .NUM_CORES(NC), .CORE_ID_W(IW)
  ) dut (
    .clk(clk), .reset(reset), .mode_nmr(mode_nmr), .core_active(core_active), .fprints(fprints),
    .task_ready(task_ready), .task_checkin(task_checkin), .task_remaining(task_remaining),
    .remaining_core_id(remaining_core_id), .task_id(task_id),
    .inc_tail_req(inc_tail_req), .inc_tail_ack(acks[R_INC]),
    .count_dec_req(count_dec_req), .count_dec_ack(acks[R_CNT]),
    .fprint_rst_req(fprint_rst_req), .fprint_rst_ack(acks[R_FPR]),
    .comp_rst_req(comp_rst_req), .comp_rst_ack(acks[R_CMP]),
    .oflow_rst_req(oflow_rst_req), .oflow_rst_ack(acks[R_OFL]),
    .status_wr(status_wr), .status_ack(acks[R_STS]),
    .mismatch(mismatch), .faulty_mask(faulty_mask), .faulty_core_id(faulty_core_id),
    .timeout_err(timeout_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int rr_m  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for any req, then require it to be exactly the expected one.
  task automatic expect_req(input int which, input string tag);
    int t = 0;
    while (reqs == 6'b0 && t < 40) begin
      tick();
      t++;
    end
    check(tag, 64'(reqs), 64'(1) << which);
  endtask

  task automatic ack_pulse(input int which);
    acks[which] = 1'b1;
    tick();
    acks[which] = 1'b0;
  endtask

  // Round-robin reference: first pending slot scanning upward from rr, wrapping.
  function automatic int ref_arb(input logic [NT-1:0] pend, input int rr);
    for (int k = 0; k < NT; k++) begin
      if (pend[(rr + k) % NT]) return (rr + k) % NT;
    end
    return -1;
  endfunction

  // Vote reference: histogram of the active fingerprints.
  task automatic ref_vote(output logic [NC-1:0] mask, output int id, output bit agr);
    int            hist [logic [CW-1:0]];
    int            n = 0;
    bit            found = 1'b0;
    logic [CW-1:0] maj = '0;
    logic [NC-1:0] act;
    act = core_active & (mode_nmr ? 3'b111 : 3'b011);
    for (int i = 0; i < NC; i++) begin
      if (act[i]) begin
        if (hist.exists(fp[i])) hist[fp[i]] = hist[fp[i]] + 1;
        else hist[fp[i]] = 1;
        n++;
      end
    end
    foreach (hist[v]) begin
      if (hist[v] * 2 > n) begin
        found = 1'b1;
        maj   = v;
      end
    end
    agr  = (hist.num() <= 1);
    mask = '0;
    for (int i = 0; i < NC; i++) mask[i] = act[i] && (!found || fp[i] != maj);
    id = 3;
    if (found) begin
      for (int i = NC - 1; i >= 0; i--) if (mask[i]) id = i;
    end
  endtask

  // Drive one full task through the DUT and check every handshake and result.
  task automatic serve(input int t, input bit clear_end);
    logic [NC-1:0] vm, em;
    int            vid, eid;
    bit            vag, mis;
    mis = 1'b0;
    em  = '0;
    eid = 3;
    if (task_ready[t]) begin
      ref_vote(vm, vid, vag);
      if (vag) begin
        expect_req(R_INC, "inc_tail_req");
        check("task_id_inc", 64'(task_id), 64'(t));
        ack_pulse(R_INC);
        expect_req(R_CNT, "count_dec_req");
        task_ready[t] = 1'b0;
        task_checkin[t] = 1'b1;
        task_remaining[t] = 1'b0;
        ack_pulse(R_CNT);
      end else begin
        mis = 1'b1;
        em  = vm;
        eid = vid;
      end
    end else if (task_remaining[t]) begin
      mis = 1'b1;
      if (int'(remaining_core_id) < NC) em[remaining_core_id] = 1'b1;
      eid = int'(remaining_core_id);
    end
    expect_req(R_FPR, "fprint_rst_req");
    check("task_id", 64'(task_id), 64'(t));
    check("mismatch", 64'(mismatch), 64'(mis));
    if (mis) begin
      check("faulty_mask", 64'(faulty_mask), 64'(em));
      check("faulty_core_id", 64'(faulty_core_id), 64'(eid));
      acks[R_STS] = 1'b1;
      tick();
      acks[R_STS] = 1'b0;
      check("foreign_ack_ignored", 64'(reqs), 64'(1) << R_FPR);
    end
    ack_pulse(R_FPR);
    expect_req(R_CMP, "comp_rst_req");
    ack_pulse(R_CMP);
    if (mis) begin
      expect_req(R_OFL, "oflow_rst_req");
      ack_pulse(R_OFL);
    end
    expect_req(R_STS, "status_wr");
    check("mismatch_at_status", 64'(mismatch), 64'(mis));
    if (clear_end) begin
      task_ready   = '0;
      task_checkin = '0;
    end
    ack_pulse(R_STS);
    rr_m = (t + 1) % NT;
  endtask

  function automatic logic [CW-1:0] pool();
    case ($urandom_range(0, 2))
      0:       return 32'h0000_000A;
      1:       return 32'h0000_000B;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    mode_nmr = 1'b1;
    core_active = 3'b111;
    for (int i = 0; i < NC; i++) fp[i] = '0;
    task_ready = '0;
    task_checkin = '0;
    task_remaining = '0;
    remaining_core_id = '0;
    acks = '0;
    repeat (3) @(negedge clk);
    check("rst_task_id", 64'(task_id), 64'(0));
    check("rst_reqs", 64'(reqs), 64'(0));
    check("rst_mismatch", 64'(mismatch), 64'(0));
    check("rst_faulty_mask", 64'(faulty_mask), 64'(0));
    check("rst_faulty_core_id", 64'(faulty_core_id), 64'(3));
    check("rst_timeout_err", 64'(timeout_err), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    tick();

    // NMR match on task 5
    for (int i = 0; i < NC; i++) fp[i] = 32'hDEAD_BEEF;
    task_ready[5] = 1'b1;
    serve(5, 1'b1);

    // Single fault: core 2 disagrees
    tick();
    fp[0] = 32'hA; fp[1] = 32'hA; fp[2] = 32'h1;
    task_ready[9] = 1'b1;
    serve(9, 1'b1);
    check("single_fault_mask", 64'(faulty_mask), 64'(3'b100));
    check("single_fault_id", 64'(faulty_core_id), 64'(2));

    // DMR mismatch: core 2 excluded, no majority
    tick();
    mode_nmr = 1'b0;
    fp[0] = 32'hA; fp[1] = 32'hB; fp[2] = 32'hA;
    task_ready[1] = 1'b1;
    serve(1, 1'b1);
    check("dmr_mask", 64'(faulty_mask), 64'(3'b011));
    check("dmr_id", 64'(faulty_core_id), 64'(3));
    mode_nmr = 1'b1;

    // Remaining-fingerprint path
    tick();
    task_checkin[7] = 1'b1;
    task_remaining[7] = 1'b1;
    remaining_core_id = 2'd1;
    serve(7, 1'b1);
    check("remaining_id", 64'(faulty_core_id), 64'(1));
    task_remaining = '0;

    // Round-robin: tasks 0 and 3 pending throughout -> 0, 3, 0
    tick();
    task_checkin[0] = 1'b1;
    task_checkin[3] = 1'b1;
    check("rr_model_first", 64'(ref_arb(task_ready | task_checkin, rr_m)), 64'(0));
    serve(0, 1'b0);
    serve(3, 1'b0);
    serve(0, 1'b1);

    // Randomized tasks against the model
    for (int it = 0; it < 30; it++) begin
      repeat (2) tick();
      mode_nmr          = 1'($urandom);
      core_active       = NC'($urandom);
      for (int i = 0; i < NC; i++) fp[i] = pool();
      remaining_core_id = IW'($urandom);
      task_ready        = NT'($urandom & $urandom & $urandom);
      task_checkin      = NT'($urandom & $urandom);
      task_remaining    = NT'($urandom);
      if ((task_ready | task_checkin) == '0) task_checkin[$urandom_range(0, NT - 1)] = 1'b1;
      serve(ref_arb(task_ready | task_checkin, rr_m), 1'b1);
    end
    task_remaining = '0;

    // Reset in the middle of a handshake drops reqs without a clock edge
    repeat (2) tick();
    task_checkin[2] = 1'b1;
    expect_req(R_FPR, "pre_reset_req");
    #2 reset = 1'b1;
    #1;
    check("async_reset_reqs", 64'(reqs), 64'(0));
    check("async_reset_task_id", 64'(task_id), 64'(0));
    task_checkin = '0;
    tick();
    reset = 1'b0;
    rr_m = 0;
    tick();
    task_checkin[4] = 1'b1;
    serve(4, 1'b1);

`ifdef FVC_ACK_TIMEOUT_EN
    begin
      int t = 0;
      repeat (2) tick();
      task_checkin[6] = 1'b1;
      expect_req(R_FPR, "tmo_fprint_req");
      ack_pulse(R_FPR);
      expect_req(R_CMP, "tmo_comp_req");
      while (!status_wr && t < 1100) begin
        tick();
        t++;
      end
      check("tmo_status_wr", 64'(status_wr), 64'(1));
      check("tmo_timeout_err", 64'(timeout_err), 64'(1));
      check("tmo_mismatch", 64'(mismatch), 64'(1));
      check("tmo_faulty_id", 64'(faulty_core_id), 64'(3));
      task_checkin = '0;
      ack_pulse(R_STS);
    end
`else
    check("timeout_err_tied", 64'(timeout_err), 64'(0));
`endif

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
